// File: rtl/timer_sequencer.sv
// Programmable countdown timer with prescaler, one-shot/periodic modes and
// pause/stop/start command handling.
module timer_sequencer #(
  parameter int WIDTH = 32,
  parameter int PW    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] load_val,
  input  logic [PW-1:0]    prescale,
  output logic [WIDTH-1:0] count,
  output logic [1:0]       state,
  output logic             busy,
  output logic             expired
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_DONE   = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [PW-1:0]    pcnt_q, pcnt_d;
  logic [PW-1:0]    psc_q, psc_d;
  logic             mode_q, mode_d;
  logic             expired_q, expired_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      pcnt_q    <= '0;
      psc_q     <= '0;
      mode_q    <= 1'b0;
      expired_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      pcnt_q    <= pcnt_d;
      psc_q     <= psc_d;
      mode_q    <= mode_d;
      expired_q <= expired_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    pcnt_d    = pcnt_q;
    psc_d     = psc_q;
    mode_d    = mode_q;
    expired_d = 1'b0;

    // Priority: stop, then a non-zero start, then per-state behaviour.
    if (stop) begin
      state_d = ST_IDLE;
      count_d = '0;
      pcnt_d  = '0;
    end else if (start && (load_val != '0)) begin
      reload_d = load_val;
      mode_d   = mode;
      psc_d    = prescale;
      count_d  = load_val;
      pcnt_d   = '0;
      state_d  = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (pcnt_q == psc_q) begin
            pcnt_d = '0;
            if (count_q == WIDTH'(1)) begin
              expired_d = 1'b1;
              if (mode_q) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = ST_DONE;
              end
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end else begin
            pcnt_d = pcnt_q + PW'(1);
          end
        end
        ST_PAUSED: begin
          if (!pause) state_d = ST_RUN;
        end
        default: ;
      endcase
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSED);
  end

  assign count   = count_q;
  assign state   = state_q;
  assign busy    = busy_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Self-checking bench for timer_sequencer: directed scenarios plus random
// command traffic compared against a behavioural timer model.
module tb_timer_sequencer;
  localparam int WIDTH = 32;
  localparam int PW    = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic             stop  = 1'b0;
  logic             pause = 1'b0;
  logic             mode  = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic [PW-1:0]    prescale = '0;
  logic [WIDTH-1:0] count;
  logic [1:0]       state;
  logic             busy;
  logic             expired;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: 0=IDLE 1=RUN 2=PAUSED 3=DONE
  int          m_state, m_phase, m_psc;
  longint      m_count, m_reload;
  bit          m_mode, m_exp;

  timer_sequencer #(.WIDTH(WIDTH), .PW(PW)) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .pause(pause),
    .mode(mode), .load_val(load_val), .prescale(prescale),
    .count(count), .state(state), .busy(busy), .expired(expired)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_count = 0; m_phase = 0; m_psc = 0;
    m_reload = 0; m_mode = 0; m_exp = 0;
  endtask

  // One rising edge of the timer described from its rules.
  task automatic model_step();
    m_exp = 0;
    if (stop) begin
      m_state = 0; m_count = 0; m_phase = 0;
    end else if (start && load_val != 0) begin
      m_reload = load_val; m_mode = mode; m_psc = int'(prescale);
      m_count = load_val; m_phase = 0; m_state = 1;
    end else if (m_state == 1 && pause) begin
      m_state = 2;
    end else if (m_state == 1) begin
      if (m_phase < m_psc) m_phase++;
      else begin
        m_phase = 0;
        m_count--;
        if (m_count == 0) begin
          m_exp = 1;
          if (m_mode) m_count = m_reload;
          else m_state = 3;
        end
      end
    end else if (m_state == 2 && !pause) begin
      m_state = 1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, longint'(count), m_count);
    check({tag, ".state"}, longint'(state), longint'(m_state));
    check({tag, ".busy"}, longint'(busy), longint'(m_state == 1 || m_state == 2));
    check({tag, ".expired"}, longint'(expired), longint'(m_exp));
  endtask

  task automatic tick(input string tag);
    @(posedge clock);
    model_step();
    #1;
    check_all(tag);
  endtask

  task automatic cmd(input bit st, input bit sp, input bit pa, input bit md,
                     input longint lv, input int ps);
    start = st; stop = sp; pause = pa; mode = md;
    load_val = WIDTH'(lv); prescale = PW'(ps);
  endtask

  initial begin
    model_reset();
    #2 reset = 1'b1;
    #1;
    check_all("reset");
    check("reset.count_lit", longint'(count), 0);
    #9 reset = 1'b0;

    cmd(0, 0, 1, 0, 0, 0);
    tick("idle_pause");

    // One-shot 3,2,1,0
    cmd(1, 0, 0, 0, 3, 0);
    tick("os_start");
    check("os.c3", longint'(count), 3);
    cmd(0, 0, 0, 1, 20, 5);
    tick("os_s1"); check("os.c2", longint'(count), 2);
    tick("os_s2"); check("os.c1", longint'(count), 1);
    tick("os_s3"); check("os.c0", longint'(count), 0);
    check("os.exp", longint'(expired), 1);
    check("os.done", longint'(state), 3);
    tick("os_after"); check("os.exp_clr", longint'(expired), 0);
    cmd(0, 0, 1, 0, 0, 0);
    tick("done_pause");

    // Periodic 2,1,2,1 with prescale 1
    cmd(1, 0, 0, 1, 2, 1);
    tick("per_start");
    cmd(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) tick("per_run");
    check("per.state", longint'(state), 1);

    // Pause mid-run at count 5
    cmd(1, 0, 0, 0, 7, 2);
    tick("pz_start");
    cmd(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) tick("pz_run");
    check("pz.c5", longint'(count), 5);
    cmd(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick("pz_hold");
    check("pz.paused", longint'(state), 2);
    check("pz.hold5", longint'(count), 5);
    cmd(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) tick("pz_resume");

    // Collisions
    cmd(1, 0, 0, 0, 9, 0);
    tick("col_restart");
    check("col.c9", longint'(count), 9);
    cmd(1, 1, 0, 0, 4, 0);
    tick("col_stopstart");
    check("col.idle", longint'(state), 0);
    cmd(1, 0, 0, 0, 1, 0);
    tick("col_load1");
    cmd(0, 1, 0, 0, 0, 0);
    tick("col_stopterm");
    check("col.noexp", longint'(expired), 0);

    // Async reset at count 7, then zero-load start
    cmd(1, 0, 0, 0, 7, 3);
    tick("ar_start");
    check("ar.c7", longint'(count), 7);
    cmd(0, 0, 0, 0, 0, 0);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check("ar.count", longint'(count), 0);
    check("ar.state", longint'(state), 0);
    check("ar.busy", longint'(busy), 0);
    #1 reset = 1'b0;
    tick("ar_idle");
    cmd(1, 0, 0, 1, 0, 0);
    tick("zero_load");
    check("zl.idle", longint'(state), 0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cmd(($urandom_range(0, 11) == 0), ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 3) == 0), 1'($urandom),
          longint'($urandom_range(0, 5)), int'($urandom_range(0, 2)));
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/timer_sequencer.md
TIMER_SEQUENCER -- requirements
Module: timer_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the counter width in bits.
REQ-002 The block SHALL have parameter PW, default 8, giving the prescale width in bits.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: latch load_val, mode and prescale, then (re)start the countdown.
REQ-006 The block SHALL have port stop, input, 1 bit: abort and return to IDLE.
REQ-007 The block SHALL have port pause, input, 1 bit: level-sensitive hold request.
REQ-008 The block SHALL have port mode, input, 1 bit: 0 = one-shot, 1 = periodic.
REQ-009 The block SHALL have port load_val, input, WIDTH bits: countdown start and reload value.
REQ-010 The block SHALL have port prescale, input, PW bits: the counter steps once every prescale+1 RUN cycles.
REQ-011 The block SHALL have port count, output, WIDTH bits: current counter value, registered.
REQ-012 The block SHALL have port state, output, 2 bits: IDLE=00, RUN=01, PAUSED=10, DONE=11.
REQ-013 The block SHALL have port busy, output, 1 bit: high when state is RUN or PAUSED, registered.
REQ-014 The block SHALL have port expired, output, 1 bit: one-cycle pulse on terminal count, registered.

Function
REQ-015 Command priority SHALL be stop > start > pause, evaluated each rising edge.
REQ-016 On stop in any state, the block SHALL go to IDLE at that edge with count=0 and prescale counter=0, and expired SHALL NOT pulse, even if a terminal step coincides.
REQ-017 On start with load_val != 0 in any state, the block SHALL at that same edge:
- latch reload=load_val, mode and prescale;
- set count=load_val and prescale counter=0;
- enter RUN.
Latency is therefore one edge.
REQ-018 Start with load_val == 0 SHALL be ignored: no state change and no expired pulse.
REQ-019 Changes to load_val, mode or prescale SHALL NOT affect an active countdown until the next start.
REQ-020 In RUN, the prescale counter SHALL increment every cycle; when it equals the latched prescale it SHALL wrap to 0 and count SHALL decrement by 1 (a step).
REQ-021 With prescale=0, count SHALL step every RUN cycle.
REQ-022 A terminal step is a step taken when count==1.
REQ-023 On a terminal step in one-shot mode: count=0, state=DONE, expired=1 for exactly one cycle.
REQ-024 On a terminal step in periodic mode: count=reload (count never shows 0), state stays RUN, expired=1 for exactly one cycle.
REQ-025 In RUN with pause=1 and no stop/start, the block SHALL enter PAUSED at that edge without stepping; count and the prescale counter SHALL hold.
REQ-026 In PAUSED with pause=0, the block SHALL return to RUN, with prescaling resuming from the held prescale-counter value.
REQ-027 In DONE, the block SHALL hold count=0 until stop (to IDLE) or start (restart); pause SHALL be ignored in IDLE and DONE.
REQ-028 Count SHALL never wrap below 0 or exceed reload; all arithmetic SHALL be WIDTH/PW bits, unsigned.
REQ-029 expired SHALL be 0 in every cycle other than the one following a terminal step.

Reset
REQ-030 While reset=1, the block SHALL immediately, without waiting for clock, set: state=IDLE, count=0, busy=0, expired=0, prescale counter=0, reload=0, latched mode=0, latched prescale=0.
REQ-031 Reset asserted mid-countdown SHALL abort without an expired pulse; after release, the block SHALL stay IDLE until start.

Verification
REQ-032 One-shot: start, load_val=3, prescale=0, mode=0 -> count 3,2,1,0 on successive edges; expired high one cycle when count=0; state=DONE; busy=0.
REQ-033 Periodic with prescale: load_val=2, prescale=1, mode=1 -> count steps every 2 cycles, sequence 2,1,2,1; expired pulses on each 1->2 reload; state stays RUN.
REQ-034 Pause: pause=1 for 5 cycles mid-run (count=5) -> state=PAUSED, count holds 5; after release, next step occurs after the remaining prescale cycles.
REQ-035 Collisions: stop and start together -> IDLE, count=0; stop on a terminal-step cycle -> no expired pulse; start during RUN with load_val=9 -> count=9 at next edge.
REQ-036 Reset and zero load: async reset asserted between clock edges while count=7 -> count=0 and state=IDLE before the next edge; start with load_val=0 -> remains IDLE.
